// File: rtl/window_3x3.sv
// window_3x3: streaming 3x3 interior-window generator built from two line buffers and column taps.
// Define WINDOW_FRAME_ERR_EN to add the oFrameErr/oErrCount truncated-frame reporting outputs.
module window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [DATA_W-1:0] iPixel,
    input  logic              iValid,
    input  logic              iSof,
    output logic [DATA_W-1:0] oNum1,
    output logic [DATA_W-1:0] oNum2,
    output logic [DATA_W-1:0] oNum3,
    output logic [DATA_W-1:0] oNum4,
    output logic [DATA_W-1:0] oNum5,
    output logic [DATA_W-1:0] oNum6,
    output logic [DATA_W-1:0] oNum7,
    output logic [DATA_W-1:0] oNum8,
    output logic [DATA_W-1:0] oNum9,
    output logic              oValid,
    output logic              oLast,
    output logic              oBusy
`ifdef WINDOW_FRAME_ERR_EN
    ,
    output logic              oFrameErr,
    output logic [15:0]       oErrCount
`endif
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] rd0, rd1;
    logic [DATA_W-1:0] top_q [2], top_d [2], mid_q [2], mid_d [2], bot_q [2], bot_d [2];
    logic [DATA_W-1:0] num_q [9], num_d [9];
    logic accept, emit, col_end, row_end, valid_q, valid_d, last_q, last_d;
    always_comb begin
        accept  = iValid & ((state_q == ACTIVE) | iSof);
        // an iSof pixel always restarts at (0,0), abandoning any frame in progress
        cur_col = iSof ? '0 : col_q;
        cur_row = iSof ? '0 : row_q;
        col_end = cur_col == CW'(IMG_WIDTH - 1);
        row_end = cur_row == RW'(IMG_HEIGHT - 1);
        emit    = accept & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
        rd0     = lb0_mem[cur_col];
        rd1     = lb1_mem[cur_col];
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        num_d   = num_q;
        valid_d = emit;
        last_d  = emit & col_end & row_end;
        if (accept) begin
            col_d   = col_end ? '0 : cur_col + 1'b1;
            row_d   = col_end ? (row_end ? '0 : cur_row + 1'b1) : cur_row;
            state_d = (col_end & row_end) ? IDLE : ACTIVE;
            top_d   = '{top_q[1], rd1};
            mid_d   = '{mid_q[1], rd0};
            bot_d   = '{bot_q[1], iPixel};
        end
        if (emit)
            num_d = '{top_q[0], top_q[1], rd1, mid_q[0], mid_q[1], rd0, bot_q[0], bot_q[1], iPixel};
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '{default: '0};
            mid_q   <= '{default: '0};
            bot_q   <= '{default: '0};
            num_q   <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end
    always_ff @(posedge iClk) begin
        if (accept) begin
            lb1_mem[cur_col] <= lb0_mem[cur_col];
            lb0_mem[cur_col] <= iPixel;
        end
    end
`ifdef WINDOW_FRAME_ERR_EN
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        err_d = iValid & iSof & (state_q == ACTIVE);
        cnt_d = (err_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign oFrameErr = err_q;
    assign oErrCount = cnt_q;
`endif
    assign oNum1  = num_q[0];
    assign oNum2  = num_q[1];
    assign oNum3  = num_q[2];
    assign oNum4  = num_q[3];
    assign oNum5  = num_q[4];
    assign oNum6  = num_q[5];
    assign oNum7  = num_q[6];
    assign oNum8  = num_q[7];
    assign oNum9  = num_q[8];
    assign oValid = valid_q;
    assign oLast  = last_q;
    assign oBusy  = state_q == ACTIVE;
endmodule
